// File: rtl/potential_decay_unit.sv
// potential_decay_unit
//   Per-neuron membrane-potential store (IEEE-754 single) feeding potential_adder.
//   On a start pulse, every stored potential is streamed out, leaked by
//   2^-DECAY_SHIFT, over a valid/ready handshake. The unit then waits for one
//   writeback per neuron and pulses done. A writeback with spike set reloads V_RESET.
// Ports
//   CLK, RESET          clock (rising edge), async active-high reset
//   start               timestep pulse, honoured only in IDLE
//   neuron_id           index of the neuron on decayed_potential
//   decayed_potential   leaked potential sent to the adder
//   out_valid/out_ready output handshake
//   wb_valid/wb_id/wb_potential/wb_spike   writeback from the adder stage
//   busy                high outside IDLE
//   done                one-cycle pulse at timestep completion
module potential_decay_unit #(
  parameter int          NUM_NEURONS = 4,
  parameter int          ADDR_W      = 2,
  parameter int          DECAY_SHIFT = 1,
  parameter logic [31:0] V_RESET     = 32'h00000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic [ADDR_W-1:0] neuron_id,
  output logic [31:0]       decayed_potential,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_id,
  input  logic [31:0]       wb_potential,
  input  logic              wb_spike,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_NEURONS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_wb_cnt;
  logic [31:0]       r_mem [NUM_NEURONS];

  logic [ADDR_W-1:0] w_next_idx;
  logic [ADDR_W-1:0] w_issue_idx;
  logic [31:0]       w_leak;
  logic              w_xfer;
  logic              w_last;

  // Exponent decrement; anything that would land at e<=0 is flushed to +0
  // (covers zero/denormal inputs too). Inf/NaN pass through untouched.
  function automatic logic [31:0] leak(input logic [31:0] f);
    logic [7:0] e;
    e = f[30:23];
    if (e == 8'hFF)                  return f;
    else if (e <= 8'(DECAY_SHIFT))   return 32'h00000000;
    else                             return {f[31], e - 8'(DECAY_SHIFT), f[22:0]};
  endfunction

  assign w_next_idx  = r_idx + 1'b1;
  // In IDLE the first issue is neuron 0; in ISSUE we preload the successor.
  assign w_issue_idx = (r_state == IDLE) ? '0 : w_next_idx;
  // Read happens before this edge's writeback lands, so a same-cycle write
  // to the issued index yields the old value.
  assign w_leak      = leak(r_mem[w_issue_idx]);
  assign w_xfer      = out_valid && out_ready;
  assign w_last      = (r_idx == IDX_LAST);

  // Writebacks are accepted in every state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= V_RESET;
    end else if (wb_valid) begin
      r_mem[wb_id] <= wb_spike ? V_RESET : wb_potential;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state           <= IDLE;
      r_idx             <= '0;
      r_wb_cnt          <= '0;
      neuron_id         <= '0;
      decayed_potential <= '0;
      out_valid         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      if (wb_valid && (r_state == ISSUE || r_state == WAIT_WB) && r_wb_cnt != CNT_FULL)
        r_wb_cnt <= r_wb_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_idx             <= '0;
            r_wb_cnt          <= '0;
            neuron_id         <= '0;
            decayed_potential <= w_leak;
            out_valid         <= 1'b1;
            busy              <= 1'b1;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_xfer) begin
            if (w_last) begin
              out_valid <= 1'b0;
              r_state   <= WAIT_WB;
            end else begin
              r_idx             <= w_next_idx;
              neuron_id         <= w_next_idx;
              decayed_potential <= w_leak;
            end
          end
        end
        WAIT_WB: begin
          if (r_wb_cnt == CNT_FULL) begin
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
